decode_stage: RTL and testbench
===============================

DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning datapath/immediate width; legal values 32, 64.
REQ-002 SHALL have parameter RV64_OPS, default 0, meaning accept RV64 opcodes (OP-IMM-32 0x1B, OP-32 0x3B) and LD/LWU/SD func3 when 1; requires XLEN=64.
REQ-003 SHALL have ports:
- clk  in  1  clock; one clock domain.
- rst  in  1  reset; synchronous, active-high.
- in_valid  in  1  upstream instruction valid.
- in_ready  out  1  stage can accept.
- in_instr  in  32  instruction word.
- in_pc  in  XLEN  instruction address.
- flush  in  1  discard all held entries.
- out_valid  out  1  decoded entry valid.
- out_ready  in  1  downstream accepts.
- out_pc  out  XLEN  passthrough pc.
- opcode  out  7  instr[6:0].
- rd_addr, rs1_addr, rs2_addr  out  5 each  register fields.
- func3  out  3; func7  out  7.
- imm  out  XLEN  sign-extended immediate per format.
- cls  out  9  one-hot {J, U_LUI, U_AUIPC, B, S, I_JALR, I_LOAD, I_MATH, R}, bit0 = R.
- illegal  out  1  unrecognised opcode/func3/func7 or instr[1:0]!=2'b11.

Function
REQ-004 SHALL register decode results: entry accepted on cycle N (in_valid&in_ready) is visible on outputs at cycle N+1; throughput one per cycle when out_ready=1.
REQ-005 SHALL hold a main register plus one skid register; states EMPTY, ONE, TWO.
REQ-006 SHALL drive in_ready = (state != TWO), registered, never dependent on out_ready combinationally.
REQ-007 Transitions: EMPTY+push->ONE; ONE+push+pop->ONE; ONE+push,no pop->TWO; ONE+pop,no push->EMPTY; TWO+pop->ONE (skid moves to main); push ignored in TWO.
REQ-008 SHALL keep all outputs stable while out_valid=1 and out_ready=0.
REQ-009 SHALL preserve order: skid entry always leaves after main entry.
REQ-010 Immediates: I = instr[31:20]; S = {instr[31:25],instr[11:7]}; B = {instr[31],instr[7],instr[30:25],instr[11:8],0}; U = {instr[31:12],12'b0}; J = {instr[31],instr[19:12],instr[20],instr[30:21],0}; all sign-extended from instr[31] to XLEN; R-type imm = 0.
REQ-011 Illegal entries SHALL still flow with illegal=1, cls=0, imm=0.
REQ-012 flush SHALL force state EMPTY next cycle; a push in the flush cycle is dropped; flush has priority over push and pop.
REQ-013 RV64_OPS=0: opcodes 0x1B/0x3B and load func3 3/6, store func3 3 SHALL flag illegal.

Reset
REQ-014 rst SHALL set state EMPTY, out_valid=0, in_ready=1 on the next clk edge.
REQ-015 rst SHALL clear all registered data outputs to 0 (opcode, addresses, func fields, imm, cls, illegal, out_pc).
REQ-016 rst mid-transfer SHALL discard held entries; no entry emerges after rst deasserts until a new push.

Structure
REQ-017 Package decode_pkg SHALL hold opcode constants, class bit indices and CLS_W=9.
REQ-018 Sub-module decode_fields (combinational: field split, immediate, cls, illegal) SHALL be instantiated once on the input path.
REQ-019 Sequencing/skid logic SHALL reside in decode_stage only.

Verification
REQ-020 Push 0xFFF00093, out_ready=1 -> next cycle opcode 0x13, rd 1, rs1 0, imm 0xFFFFFFFF, cls bit I_MATH, illegal 0.
REQ-021 Push 0x00112623 -> opcode 0x23, rs1 2, rs2 1, func3 2, imm 0x0000000C, cls S; push 0xFE000EE3 -> imm 0xFFFFFFFC, cls B.
REQ-022 XLEN=64: push 0x800002B7 -> imm 0xFFFFFFFF80000000, cls U_LUI; RV64_OPS=0 push 0x0000001B -> illegal 1.
REQ-023 out_ready=0, push A,B -> in_ready 0 after B, outputs hold A; raise out_ready -> A then B on consecutive cycles, none lost or duplicated.
REQ-024 State TWO, assert flush with in_valid=1 -> next cycle out_valid 0, in_ready 1, pushed word never appears.
REQ-025 Assert rst while ONE -> next cycle out_valid 0, all data outputs 0, in_ready 1.

Source files
------------

// File: rtl/decode_pkg.sv
// Shared constants for the decode stage: RV opcodes, one-hot class bit positions
// and the occupancy states of the output buffer.
package decode_pkg;

    localparam int CLS_W = 9;

    localparam logic [6:0] OP_LUI    = 7'h37;
    localparam logic [6:0] OP_AUIPC  = 7'h17;
    localparam logic [6:0] OP_JAL    = 7'h6F;
    localparam logic [6:0] OP_JALR   = 7'h67;
    localparam logic [6:0] OP_BRANCH = 7'h63;
    localparam logic [6:0] OP_LOAD   = 7'h03;
    localparam logic [6:0] OP_STORE  = 7'h23;
    localparam logic [6:0] OP_IMM    = 7'h13;
    localparam logic [6:0] OP_OP     = 7'h33;
    localparam logic [6:0] OP_IMM_32 = 7'h1B;
    localparam logic [6:0] OP_32     = 7'h3B;

    localparam int CLS_R       = 0;
    localparam int CLS_I_MATH  = 1;
    localparam int CLS_I_LOAD  = 2;
    localparam int CLS_I_JALR  = 3;
    localparam int CLS_B       = 4;
    localparam int CLS_S       = 5;
    localparam int CLS_U_AUIPC = 6;
    localparam int CLS_U_LUI   = 7;
    localparam int CLS_J       = 8;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_t;

endpackage

// File: rtl/decode_if.sv
// Instruction-in / decoded-entry-out bundle of the decode stage. The stage is
// the slave; the master supplies instructions and consumes decoded entries.
interface decode_if
    import decode_pkg::*;
#(
    parameter int XLEN = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_instr;
    logic [XLEN-1:0]  in_pc;
    logic             flush;
    logic             out_valid;
    logic             out_ready;
    logic [XLEN-1:0]  out_pc;
    logic [6:0]       opcode;
    logic [4:0]       rd_addr;
    logic [4:0]       rs1_addr;
    logic [4:0]       rs2_addr;
    logic [2:0]       func3;
    logic [6:0]       func7;
    logic [XLEN-1:0]  imm;
    logic [CLS_W-1:0] cls;
    logic             illegal;

    modport slave (
        input  in_valid, in_instr, in_pc, flush, out_ready,
        output in_ready, out_valid, out_pc, opcode, rd_addr, rs1_addr, rs2_addr,
               func3, func7, imm, cls, illegal
    );

    modport master (
        output in_valid, in_instr, in_pc, flush, out_ready,
        input  in_ready, out_valid, out_pc, opcode, rd_addr, rs1_addr, rs2_addr,
               func3, func7, imm, cls, illegal
    );
endinterface

// File: rtl/decode_fields.sv
// Purely combinational RV32/RV64 field split, immediate build, class and
// legality check for one instruction word.
module decode_fields
    import decode_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int RV64_OPS = 0
) (
    input  logic [31:0]      i_instr,
    output logic [6:0]       o_opcode,
    output logic [4:0]       o_rd,
    output logic [4:0]       o_rs1,
    output logic [4:0]       o_rs2,
    output logic [2:0]       o_func3,
    output logic [6:0]       o_func7,
    output logic [XLEN-1:0]  o_imm,
    output logic [CLS_W-1:0] o_cls,
    output logic             o_illegal
);
    localparam bit RV64_EN = (RV64_OPS != 0);

    logic [31:0]      w_imm_i, w_imm_s, w_imm_b, w_imm_u, w_imm_j, w_imm32;
    logic [CLS_W-1:0] w_cls;
    logic [6:0]       w_shamt_hi;
    logic             w_legal;
    logic             w_illegal;

    assign o_opcode = i_instr[6:0];
    assign o_rd     = i_instr[11:7];
    assign o_func3  = i_instr[14:12];
    assign o_rs1    = i_instr[19:15];
    assign o_rs2    = i_instr[24:20];
    assign o_func7  = i_instr[31:25];

    assign w_imm_i = {{20{i_instr[31]}}, i_instr[31:20]};
    assign w_imm_s = {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
    assign w_imm_b = {{19{i_instr[31]}}, i_instr[31], i_instr[7], i_instr[30:25], i_instr[11:8], 1'b0};
    assign w_imm_u = {i_instr[31:12], 12'b0};
    assign w_imm_j = {{11{i_instr[31]}}, i_instr[31], i_instr[19:12], i_instr[20], i_instr[30:21], 1'b0};

    // RV64 shifts borrow instr[25] as shamt[5], so only instr[31:26] qualifies the op
    assign w_shamt_hi = RV64_EN ? {i_instr[31:26], 1'b0} : o_func7;

    always_comb begin
        w_cls   = '0;
        w_imm32 = '0;
        w_legal = 1'b0;
        case (o_opcode)
            OP_LUI:    begin w_cls[CLS_U_LUI] = 1'b1;   w_imm32 = w_imm_u; w_legal = 1'b1; end
            OP_AUIPC:  begin w_cls[CLS_U_AUIPC] = 1'b1; w_imm32 = w_imm_u; w_legal = 1'b1; end
            OP_JAL:    begin w_cls[CLS_J] = 1'b1;       w_imm32 = w_imm_j; w_legal = 1'b1; end
            OP_JALR:   begin w_cls[CLS_I_JALR] = 1'b1;  w_imm32 = w_imm_i; w_legal = (o_func3 == 3'd0); end
            OP_BRANCH: begin
                w_cls[CLS_B] = 1'b1;
                w_imm32      = w_imm_b;
                w_legal      = !(o_func3 inside {3'd2, 3'd3});
            end
            OP_LOAD: begin
                w_cls[CLS_I_LOAD] = 1'b1;
                w_imm32           = w_imm_i;
                w_legal           = (o_func3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})
                                 || (RV64_EN && (o_func3 inside {3'd3, 3'd6}));
            end
            OP_STORE: begin
                w_cls[CLS_S] = 1'b1;
                w_imm32      = w_imm_s;
                w_legal      = (o_func3 <= 3'd2) || (RV64_EN && (o_func3 == 3'd3));
            end
            OP_IMM: begin
                w_cls[CLS_I_MATH] = 1'b1;
                w_imm32           = w_imm_i;
                if (o_func3 == 3'd1)
                    w_legal = (w_shamt_hi == 7'h00);
                else if (o_func3 == 3'd5)
                    w_legal = (w_shamt_hi inside {7'h00, 7'h20});
                else
                    w_legal = 1'b1;
            end
            OP_OP: begin
                w_cls[CLS_R] = 1'b1;
                w_legal      = (o_func7 == 7'h00)
                            || ((o_func7 == 7'h20) && (o_func3 inside {3'd0, 3'd5}));
            end
            OP_IMM_32: begin
                w_cls[CLS_I_MATH] = 1'b1;
                w_imm32           = w_imm_i;
                w_legal           = RV64_EN && ((o_func3 == 3'd0)
                                 || ((o_func3 == 3'd1) && (o_func7 == 7'h00))
                                 || ((o_func3 == 3'd5) && (o_func7 inside {7'h00, 7'h20})));
            end
            OP_32: begin
                w_cls[CLS_R] = 1'b1;
                w_legal      = RV64_EN && (((o_func7 == 7'h00) && (o_func3 inside {3'd0, 3'd1, 3'd5}))
                            || ((o_func7 == 7'h20) && (o_func3 inside {3'd0, 3'd5})));
            end
            default: w_legal = 1'b0;
        endcase
    end

    assign w_illegal = !w_legal || (i_instr[1:0] != 2'b11);
    assign o_illegal = w_illegal;
    assign o_cls     = w_illegal ? '0 : w_cls;
    assign o_imm     = w_illegal ? '0 : XLEN'($signed(w_imm32));

endmodule

// File: rtl/decode_stage.sv
// Registered decode stage: decodes on the input path and holds results in a
// main register backed by one skid register so in_ready can be registered.
module decode_stage
    import decode_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int RV64_OPS = 0
) (
    input  logic     clk,
    input  logic     rst,
    decode_if.slave  bus
);
    // {pc, imm, opcode, rd, rs1, rs2, func3, func7, cls, illegal}
    localparam int ENTRY_W = 2 * XLEN + 32 + CLS_W + 1;

    logic [6:0]       w_opcode;
    logic [4:0]       w_rd, w_rs1, w_rs2;
    logic [2:0]       w_func3;
    logic [6:0]       w_func7;
    logic [XLEN-1:0]  w_imm;
    logic [CLS_W-1:0] w_cls;
    logic             w_illegal;

    logic [ENTRY_W-1:0] w_entry, r_main, r_skid, w_main_next, w_skid_next;
    state_t             r_state, w_state_next;
    logic               r_in_ready;
    logic               w_push, w_pop;

    decode_fields #(
        .XLEN     (XLEN),
        .RV64_OPS (RV64_OPS)
    ) u_fields (
        .i_instr   (bus.in_instr),
        .o_opcode  (w_opcode),
        .o_rd      (w_rd),
        .o_rs1     (w_rs1),
        .o_rs2     (w_rs2),
        .o_func3   (w_func3),
        .o_func7   (w_func7),
        .o_imm     (w_imm),
        .o_cls     (w_cls),
        .o_illegal (w_illegal)
    );

    assign w_entry = {bus.in_pc, w_imm, w_opcode, w_rd, w_rs1, w_rs2, w_func3, w_func7, w_cls, w_illegal};

    // r_in_ready is low exactly in TWO, which is what drops pushes there
    assign w_push = bus.in_valid & r_in_ready;
    assign w_pop  = (r_state != ST_EMPTY) & bus.out_ready;

    always_comb begin
        w_state_next = r_state;
        w_main_next  = r_main;
        w_skid_next  = r_skid;
        if (bus.flush) begin
            w_state_next = ST_EMPTY;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_push) begin
                        w_state_next = ST_ONE;
                        w_main_next  = w_entry;
                    end
                end
                ST_ONE: begin
                    if (w_push && w_pop) begin
                        w_main_next = w_entry;
                    end else if (w_push) begin
                        w_state_next = ST_TWO;
                        w_skid_next  = w_entry;
                    end else if (w_pop) begin
                        w_state_next = ST_EMPTY;
                    end
                end
                ST_TWO: begin
                    if (w_pop) begin
                        w_state_next = ST_ONE;
                        w_main_next  = r_skid;
                    end
                end
                default: w_state_next = ST_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_EMPTY;
            r_main     <= '0;
            r_skid     <= '0;
            r_in_ready <= 1'b1;
        end else begin
            r_state    <= w_state_next;
            r_main     <= w_main_next;
            r_skid     <= w_skid_next;
            r_in_ready <= (w_state_next != ST_TWO);
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = (r_state != ST_EMPTY);
    assign {bus.out_pc, bus.imm, bus.opcode, bus.rd_addr, bus.rs1_addr, bus.rs2_addr,
            bus.func3, bus.func7, bus.cls, bus.illegal} = r_main;

endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench: three decode_stage builds (RV32, RV64 without and with the
// RV64 opcodes) share one stimulus stream; expectations come from a vector table.
`timescale 1ns/1ps
module tb_decode_stage;
    import decode_pkg::*;

    localparam int NV = 18;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    decode_if #(.XLEN(32)) bus32 ();
    decode_if #(.XLEN(64)) bus64a ();
    decode_if #(.XLEN(64)) bus64b ();

    decode_stage #(.XLEN(32), .RV64_OPS(0)) dut32  (.clk(clk), .rst(rst), .bus(bus32));
    decode_stage #(.XLEN(64), .RV64_OPS(0)) dut64a (.clk(clk), .rst(rst), .bus(bus64a));
    decode_stage #(.XLEN(64), .RV64_OPS(1)) dut64b (.clk(clk), .rst(rst), .bus(bus64b));

    logic rdy_man, bp_en, bp_rand;
    assign bus32.out_ready  = bp_en ? bp_rand : rdy_man;
    assign bus64a.in_valid  = bus32.in_valid;
    assign bus64a.in_instr  = bus32.in_instr;
    assign bus64a.in_pc     = {32'hFF00_0000, bus32.in_pc};
    assign bus64a.flush     = bus32.flush;
    assign bus64a.out_ready = bus32.out_ready;
    assign bus64b.in_valid  = bus32.in_valid;
    assign bus64b.in_instr  = bus32.in_instr;
    assign bus64b.in_pc     = {32'hFF00_0000, bus32.in_pc};
    assign bus64b.flush     = bus32.flush;
    assign bus64b.out_ready = bus32.out_ready;

    // imm is the legal-decode value (32-bit); ill32 applies to RV64_OPS=0 builds
    logic [31:0] v_instr [NV] = '{32'hFFF00093, 32'h00112623, 32'hFE000EE3, 32'h800002B7,
                                  32'h0000001B, 32'h00000033, 32'h40208133, 32'h0000006F,
                                  32'h00008067, 32'h12345017, 32'hFF803083, 32'h00000010,
                                  32'h02000033, 32'h0040A183, 32'h00103423, 32'h4030D093,
                                  32'hFFDFF0EF, 32'h0000003B};
    logic [31:0] v_imm   [NV] = '{32'hFFFFFFFF, 32'h0000000C, 32'hFFFFFFFC, 32'h80000000,
                                  32'h0, 32'h0, 32'h0, 32'h0,
                                  32'h0, 32'h12345000, 32'hFFFFFFF8, 32'h0,
                                  32'h0, 32'h00000004, 32'h00000008, 32'h00000403,
                                  32'hFFFFFFFC, 32'h0};
    logic [8:0]  v_cls   [NV] = '{9'h002, 9'h020, 9'h010, 9'h080, 9'h002, 9'h001, 9'h001, 9'h100,
                                  9'h008, 9'h040, 9'h004, 9'h000, 9'h000, 9'h004, 9'h020, 9'h002,
                                  9'h100, 9'h001};
    logic        v_ill32 [NV] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 1, 1, 0, 1, 0, 0, 1};
    logic        v_ill64 [NV] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0};

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] imm;
        logic [8:0]  cls;
        logic        ill32;
        logic        ill64;
    } exp_t;

    exp_t        sb_q [$];
    exp_t        mon_e;
    int          n_vec  = 0;
    int          n_miss = 0;
    logic [31:0] pc_ctr, pc_a, pc_b;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic check_entry(input exp_t e);
        logic [63:0] sx;
        sx = {{32{e.imm[31]}}, e.imm};
        check_val("d32_pc", 64'(bus32.out_pc), 64'(e.pc));
        check_val("d32_fields",
                  64'({bus32.opcode, bus32.rd_addr, bus32.rs1_addr, bus32.rs2_addr, bus32.func3, bus32.func7}),
                  64'({e.instr[6:0], e.instr[11:7], e.instr[19:15], e.instr[24:20], e.instr[14:12], e.instr[31:25]}));
        check_val("d32_imm", 64'(bus32.imm), e.ill32 ? 64'd0 : 64'(e.imm));
        check_val("d32_cls", 64'(bus32.cls), e.ill32 ? 64'd0 : 64'(e.cls));
        check_val("d32_illegal", 64'(bus32.illegal), 64'(e.ill32));
        check_val("d64a_valid", 64'(bus64a.out_valid), 64'd1);
        check_val("d64a_pc", bus64a.out_pc, {32'hFF00_0000, e.pc});
        check_val("d64a_imm", bus64a.imm, e.ill32 ? 64'd0 : sx);
        check_val("d64a_cls", 64'(bus64a.cls), e.ill32 ? 64'd0 : 64'(e.cls));
        check_val("d64a_illegal", 64'(bus64a.illegal), 64'(e.ill32));
        check_val("d64b_valid", 64'(bus64b.out_valid), 64'd1);
        check_val("d64b_imm", bus64b.imm, e.ill64 ? 64'd0 : sx);
        check_val("d64b_cls", 64'(bus64b.cls), e.ill64 ? 64'd0 : 64'(e.cls));
        check_val("d64b_illegal", 64'(bus64b.illegal), 64'(e.ill64));
        $display("xact instr=%h pc=%h imm32=%h imm64a=%h cls=%h illegal=%b/%b/%b",
                 e.instr, bus32.out_pc, bus32.imm, bus64a.imm, bus32.cls,
                 bus32.illegal, bus64a.illegal, bus64b.illegal);
    endtask

    task automatic check_idle_zero(input string tag);
        check_val({tag, "_valid"}, 64'(bus32.out_valid), 64'd0);
        check_val({tag, "_in_ready"}, 64'(bus32.in_ready), 64'd1);
        check_val({tag, "_pc_imm"}, {bus32.out_pc, bus32.imm}, 64'd0);
        check_val({tag, "_fields"},
                  64'({bus32.opcode, bus32.rd_addr, bus32.rs1_addr, bus32.rs2_addr,
                       bus32.func3, bus32.func7, bus32.cls, bus32.illegal}), 64'd0);
        check_val({tag, "_d64_valid"}, 64'(bus64a.out_valid), 64'd0);
        check_val({tag, "_d64_pc"}, bus64a.out_pc, 64'd0);
        check_val({tag, "_d64_imm"}, bus64a.imm, 64'd0);
    endtask

    // Called right after a rising edge; returns right after the edge that took the word.
    task automatic send(input int k);
        exp_t e;
        int   waited;
        waited          = 0;
        bus32.in_valid  = 1'b1;
        bus32.in_instr  = v_instr[k];
        bus32.in_pc     = pc_ctr;
        @(negedge clk);
        while (!bus32.in_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (!bus32.in_ready) begin
            check_val("in_ready_timeout", 64'(bus32.in_ready), 64'd1);
        end else begin
            e.instr = v_instr[k];
            e.pc    = pc_ctr;
            e.imm   = v_imm[k];
            e.cls   = v_cls[k];
            e.ill32 = v_ill32[k];
            e.ill64 = v_ill64[k];
            sb_q.push_back(e);
        end
        @(posedge clk);
        #1;
        bus32.in_valid = 1'b0;
        pc_ctr         = pc_ctr + 32'd4;
    endtask

    always @(negedge clk) begin
        if (!rst && bus32.out_valid && bus32.out_ready) begin
            if (sb_q.size() == 0) begin
                check_val("spurious_out", 64'(bus32.out_valid), 64'd0);
            end else begin
                mon_e = sb_q.pop_front();
                check_entry(mon_e);
            end
        end
    end

    always @(posedge clk) begin
        #1;
        bp_rand = 1'($urandom_range(0, 1));
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus32.in_valid = 1'b0;
        bus32.in_instr = '0;
        bus32.in_pc    = '0;
        bus32.flush    = 1'b0;
        rdy_man        = 1'b0;
        bp_en          = 1'b0;
        pc_ctr         = 32'h0000_1000;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check_idle_zero("reset");
        @(posedge clk); #1;
        rst     = 1'b0;
        rdy_man = 1'b1;

        // Single push: visible on the cycle after acceptance
        send(0);
        @(negedge clk);
        check_val("latency_valid", 64'(bus32.out_valid), 64'd1);
        @(posedge clk); #1;

        for (int k = 1; k < NV; k++) send(k);
        repeat (4) @(posedge clk); #1;
        check_val("drain_stream", 64'(sb_q.size()), 64'd0);

        // Back-pressure: fill main + skid, hold A, then release A then B
        rdy_man = 1'b0;
        pc_a = pc_ctr; send(2);
        pc_b = pc_ctr; send(9);
        @(negedge clk);
        check_val("full_in_ready", 64'(bus32.in_ready), 64'd0);
        check_val("hold_a_pc", 64'(bus32.out_pc), 64'(pc_a));
        @(posedge clk); #1;
        bus32.in_valid = 1'b1;
        bus32.in_instr = 32'h00000013;
        bus32.in_pc    = 32'hDEAD_0000;
        repeat (2) @(posedge clk);
        #1 bus32.in_valid = 1'b0;
        @(negedge clk);
        check_val("hold_a_pc2", 64'(bus32.out_pc), 64'(pc_a));
        check_val("hold_a_imm", 64'(bus32.imm), 64'(v_imm[2]));
        @(posedge clk); #1;
        rdy_man = 1'b1;
        @(negedge clk);
        check_val("consec_a", 64'(bus32.out_pc), 64'(pc_a));
        @(negedge clk);
        check_val("consec_b", 64'(bus32.out_pc), 64'(pc_b));
        @(negedge clk);
        check_val("after_b_idle", 64'(bus32.out_valid), 64'd0);
        @(posedge clk); #1;

        // Flush from TWO with a concurrent push
        rdy_man = 1'b0;
        send(3);
        send(4);
        bus32.in_valid = 1'b1;
        bus32.in_instr = v_instr[5];
        bus32.in_pc    = 32'hBAD0_0000;
        bus32.flush    = 1'b1;
        @(posedge clk); #1;
        bus32.flush    = 1'b0;
        bus32.in_valid = 1'b0;
        sb_q.delete();
        @(negedge clk);
        check_val("flush_two_valid", 64'(bus32.out_valid), 64'd0);
        check_val("flush_two_in_ready", 64'(bus32.in_ready), 64'd1);
        @(posedge clk); #1;

        // Flush from ONE, where the concurrent push would otherwise be taken
        send(6);
        bus32.in_valid = 1'b1;
        bus32.in_instr = v_instr[7];
        bus32.in_pc    = 32'hBAD1_0000;
        bus32.flush    = 1'b1;
        @(posedge clk); #1;
        bus32.flush    = 1'b0;
        bus32.in_valid = 1'b0;
        sb_q.delete();
        @(negedge clk);
        check_val("flush_one_valid", 64'(bus32.out_valid), 64'd0);
        @(posedge clk); #1;
        rdy_man = 1'b1;
        repeat (5) @(posedge clk); #1;
        check_val("post_flush_idle", 64'(bus32.out_valid), 64'd0);

        // Reset while one entry is held
        rdy_man = 1'b0;
        send(7);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_idle_zero("rst_mid");
        sb_q.delete();
        @(posedge clk); #1;
        rst     = 1'b0;
        rdy_man = 1'b1;
        repeat (4) @(posedge clk); #1;
        check_val("post_rst_idle", 64'(bus32.out_valid), 64'd0);

        // Random back-pressure over the whole table, both directions
        bp_en = 1'b1;
        for (int k = 0; k < NV; k++) send(k);
        for (int k = 0; k < NV; k++) send(NV - 1 - k);
        bp_en   = 1'b0;
        rdy_man = 1'b1;
        repeat (6) @(posedge clk); #1;
        check_val("drain_final", 64'(sb_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
